// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and data access.
// Data wins arbitration, with a bounded fetch-starvation streak and a sticky watchdog abort.
module mem_port_arbiter #(
  parameter int              AW           = 32,
  parameter int              DW           = 32,
  parameter int              MAX_D_STREAK = 4,
  parameter int              TIMEOUT      = 64,
  parameter logic [DW-1:0]   ERR_DATA     = '0
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  output logic [DW-1:0] if_rdata_o,
  output logic          if_done_o,
  input  logic          d_req_i,
  input  logic          d_we_i,
  input  logic [AW-1:0] d_addr_i,
  input  logic [DW-1:0] d_wdata_i,
  output logic [DW-1:0] d_rdata_o,
  output logic          d_done_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i,
  input  logic          mem_ready_i,
  output logic          stall_o,
  output logic          timeout_o
);

  // state   | meaning
  // IDLE    | no transaction outstanding, arbitrating
  // BUSY_D  | data load/store outstanding
  // BUSY_IF | instruction fetch outstanding
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] BUSY_D  = 2'd1;
  localparam logic [1:0] BUSY_IF = 2'd2;

  localparam int ST_W = (MAX_D_STREAK > 0) ? $clog2(MAX_D_STREAK + 1) : 1;
  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [1:0]      state;
  logic [ST_W-1:0] streak;
  logic [WD_W-1:0] wd_cnt;
  logic            if_elig;
  logic            d_elig;
  logic            streak_at_max;
  logic            streak_full;
  logic            grant_d;
  logic            grant_if;
  logic            wd_expire;

  // A requester is not eligible in its own done cycle: its req is still the old one.
  assign if_elig       = if_req_i & ~if_done_o;
  assign d_elig        = d_req_i & ~d_done_o;
  assign streak_at_max = (streak == ST_W'(MAX_D_STREAK));
  assign streak_full   = (MAX_D_STREAK != 0) && streak_at_max;
  assign grant_d       = (state == IDLE) && d_elig && !(if_elig && streak_full);
  assign grant_if      = (state == IDLE) && !grant_d && if_elig;
  assign wd_expire     = (TIMEOUT != 0) && (wd_cnt == WD_W'(TIMEOUT - 1));
  assign stall_o       = (if_req_i & ~if_done_o) | (d_req_i & ~d_done_o);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= IDLE;
      streak      <= '0;
      wd_cnt      <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      if_done_o   <= 1'b0;
      d_done_o    <= 1'b0;
      if_rdata_o  <= '0;
      d_rdata_o   <= '0;
      timeout_o   <= 1'b0;
    end else begin
      if_done_o <= 1'b0;
      d_done_o  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            state       <= BUSY_D;
            mem_req_o   <= 1'b1;
            mem_we_o    <= d_we_i;
            mem_addr_o  <= d_addr_i;
            mem_wdata_o <= d_wdata_i;
            wd_cnt      <= '0;
            if (!if_elig) streak <= '0;
            else if (!streak_at_max) streak <= streak + 1'b1;
          end else if (grant_if) begin
            state       <= BUSY_IF;
            mem_req_o   <= 1'b1;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= if_addr_i;
            mem_wdata_o <= '0;
            wd_cnt      <= '0;
            streak      <= '0;
          end
        end
        BUSY_D, BUSY_IF: begin
          // A ready arriving on the last watchdog cycle still completes normally.
          if (mem_ready_i) begin
            state     <= IDLE;
            mem_req_o <= 1'b0;
            if (state == BUSY_D) begin
              d_done_o <= 1'b1;
              if (!mem_we_o) d_rdata_o <= mem_rdata_i;
            end else begin
              if_done_o  <= 1'b1;
              if_rdata_o <= mem_rdata_i;
            end
          end else if (wd_expire) begin
            state     <= IDLE;
            mem_req_o <= 1'b0;
            timeout_o <= 1'b1;
            if (state == BUSY_D) begin
              d_done_o  <= 1'b1;
              d_rdata_o <= ERR_DATA;
            end else begin
              if_done_o  <= 1'b1;
              if_rdata_o <= ERR_DATA;
            end
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one task per scenario, inline checks.
// A small negedge memory responder answers mem_req_o after a programmable delay.
module tb_mem_port_arbiter;

  localparam int          AW  = 32;
  localparam int          DW  = 32;
  localparam logic [31:0] ERR = 32'hBAD0_0BAD;

  logic          clk_i = 1'b0;
  logic          rst_n_i;
  logic          if_req_i;
  logic [AW-1:0] if_addr_i;
  logic [DW-1:0] if_rdata_o;
  logic          if_done_o;
  logic          d_req_i;
  logic          d_we_i;
  logic [AW-1:0] d_addr_i;
  logic [DW-1:0] d_wdata_i;
  logic [DW-1:0] d_rdata_o;
  logic          d_done_o;
  logic          mem_req_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [DW-1:0] mem_rdata_i;
  logic          mem_ready_i;
  logic          stall_o;
  logic          timeout_o;

  int          n_cmp = 0;
  int          n_err = 0;
  logic        resp_en;
  int          resp_delay;
  logic [31:0] resp_data;
  logic        force_ready;
  int          rcnt;

  mem_port_arbiter #(
    .AW(AW), .DW(DW), .MAX_D_STREAK(4), .TIMEOUT(8), .ERR_DATA(ERR)
  ) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_done_o(if_done_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_rdata_o(d_rdata_o), .d_done_o(d_done_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .mem_ready_i(mem_ready_i),
    .stall_o(stall_o), .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  // Memory model: ready in the (resp_delay+1)-th cycle that mem_req_o is high.
  initial begin
    mem_ready_i = 1'b0;
    mem_rdata_i = '0;
    rcnt = 0;
    forever begin
      @(negedge clk_i);
      if (mem_req_o) begin
        rcnt = rcnt + 1;
        mem_ready_i = force_ready | (resp_en && (rcnt == resp_delay + 1));
      end else begin
        rcnt = 0;
        mem_ready_i = force_ready;
      end
      mem_rdata_i = resp_data;
    end
  end

  task automatic tick;
    @(posedge clk_i);
    #2;
  endtask

  task automatic test_reset;
    repeat (3) tick();
    n_cmp++; if (mem_req_o !== 1'b0) begin n_err++; $display("FAIL rst_mem_req got %0h exp 0", mem_req_o); end
    n_cmp++; if (mem_we_o !== 1'b0) begin n_err++; $display("FAIL rst_mem_we got %0h exp 0", mem_we_o); end
    n_cmp++; if (mem_addr_o !== 32'h0) begin n_err++; $display("FAIL rst_mem_addr got %0h exp 0", mem_addr_o); end
    n_cmp++; if (mem_wdata_o !== 32'h0) begin n_err++; $display("FAIL rst_mem_wdata got %0h exp 0", mem_wdata_o); end
    n_cmp++; if ({if_done_o, d_done_o} !== 2'b00) begin n_err++; $display("FAIL rst_done got %0b exp 00", {if_done_o, d_done_o}); end
    n_cmp++; if ({if_rdata_o, d_rdata_o} !== 64'h0) begin n_err++; $display("FAIL rst_rdata got %0h/%0h exp 0/0", if_rdata_o, d_rdata_o); end
    n_cmp++; if ({timeout_o, stall_o} !== 2'b00) begin n_err++; $display("FAIL rst_timeout_stall got %0b exp 00", {timeout_o, stall_o}); end
    rst_n_i = 1'b1;
    tick();
  endtask

  task automatic test_single_fetch;
    resp_en = 1'b1; resp_delay = 1; resp_data = 32'h8C01_0004;
    if_addr_i = 32'h40; if_req_i = 1'b1;
    #1;
    n_cmp++; if ({stall_o, mem_req_o} !== 2'b10) begin n_err++; $display("FAIL f_c0 stall/req got %0b exp 10", {stall_o, mem_req_o}); end
    tick();
    n_cmp++; if ({stall_o, mem_req_o, mem_we_o} !== 3'b110) begin n_err++; $display("FAIL f_c1 stall/req/we got %0b exp 110", {stall_o, mem_req_o, mem_we_o}); end
    n_cmp++; if (mem_addr_o !== 32'h40) begin n_err++; $display("FAIL f_c1 addr got %0h exp 40", mem_addr_o); end
    tick();
    n_cmp++; if ({stall_o, mem_req_o, if_done_o} !== 3'b110) begin n_err++; $display("FAIL f_c2 stall/req/done got %0b exp 110", {stall_o, mem_req_o, if_done_o}); end
    tick();
    n_cmp++; if ({stall_o, mem_req_o, if_done_o} !== 3'b001) begin n_err++; $display("FAIL f_c3 stall/req/done got %0b exp 001", {stall_o, mem_req_o, if_done_o}); end
    n_cmp++; if (if_rdata_o !== 32'h8C01_0004) begin n_err++; $display("FAIL f_rdata got %0h exp 8c010004", if_rdata_o); end
    if_req_i = 1'b0;
    tick();
    n_cmp++; if ({if_done_o, mem_req_o} !== 2'b00) begin n_err++; $display("FAIL f_c4 done/req got %0b exp 00", {if_done_o, mem_req_o}); end
  endtask

  task automatic test_data_priority;
    resp_en = 1'b1; resp_delay = 0; resp_data = 32'h1111_2222;
    if_addr_i = 32'h44; if_req_i = 1'b1;
    d_addr_i = 32'h100; d_wdata_i = 32'hDEAD_BEEF; d_we_i = 1'b1; d_req_i = 1'b1;
    tick();
    n_cmp++; if ({mem_req_o, mem_we_o} !== 2'b11) begin n_err++; $display("FAIL p_c1 req/we got %0b exp 11", {mem_req_o, mem_we_o}); end
    n_cmp++; if ({mem_addr_o, mem_wdata_o} !== {32'h100, 32'hDEAD_BEEF}) begin n_err++; $display("FAIL p_c1 addr/wdata got %0h/%0h exp 100/deadbeef", mem_addr_o, mem_wdata_o); end
    tick();
    n_cmp++; if ({d_done_o, if_done_o, mem_req_o, stall_o} !== 4'b1001) begin n_err++; $display("FAIL p_c2 ddone/ifdone/req/stall got %0b exp 1001", {d_done_o, if_done_o, mem_req_o, stall_o}); end
    n_cmp++; if (d_rdata_o !== 32'h0) begin n_err++; $display("FAIL p_store_rdata got %0h exp 0", d_rdata_o); end
    d_req_i = 1'b0;
    tick();
    n_cmp++; if ({mem_req_o, mem_we_o, d_done_o} !== 3'b100) begin n_err++; $display("FAIL p_c3 req/we/ddone got %0b exp 100", {mem_req_o, mem_we_o, d_done_o}); end
    n_cmp++; if (mem_addr_o !== 32'h44) begin n_err++; $display("FAIL p_c3 addr got %0h exp 44", mem_addr_o); end
    tick();
    n_cmp++; if ({if_done_o, if_rdata_o} !== {1'b1, 32'h1111_2222}) begin n_err++; $display("FAIL p_c4 ifdone/rdata got %0b/%0h exp 1/11112222", if_done_o, if_rdata_o); end
    if_req_i = 1'b0;
    tick();
  endtask

  // Fetch request is withheld in every data done cycle, so the streak decides each contested grant.
  task automatic test_streak;
    int   exp_if[11] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1};
    int   ng = 0;
    logic prev;
    logic is_if;
    resp_en = 1'b1; resp_delay = 0; resp_data = 32'h5555_AAAA;
    d_we_i = 1'b0; d_addr_i = 32'h200; if_addr_i = 32'h300;
    d_req_i = 1'b1; if_req_i = 1'b1;
    prev = mem_req_o;
    for (int c = 0; c < 300 && ng < 11; c++) begin
      tick();
      if (mem_req_o && !prev) begin
        is_if = (mem_addr_o == 32'h300);
        n_cmp++;
        if (int'(is_if) != exp_if[ng]) begin n_err++; $display("FAIL s_grant%0d got if=%0d exp if=%0d", ng, is_if, exp_if[ng]); end
        ng++;
      end
      prev = mem_req_o;
      if (ng < 11) if_req_i = ~d_done_o;
    end
    d_req_i = 1'b0;
    n_cmp++; if (ng != 11) begin n_err++; $display("FAIL s_grant_count got %0d exp 11", ng); end
    for (int c = 0; c < 20 && !if_done_o; c++) tick();
    n_cmp++; if (if_done_o !== 1'b1) begin n_err++; $display("FAIL s_if_done got %0b exp 1", if_done_o); end
    if_req_i = 1'b0;
    tick();
  endtask

  task automatic test_watchdog;
    resp_en = 1'b0; resp_data = 32'h7777_7777;
    d_we_i = 1'b0; d_addr_i = 32'h80; d_req_i = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      n_cmp++; if ({mem_req_o, d_done_o, timeout_o} !== 3'b100) begin n_err++; $display("FAIL w_busy_c%0d req/done/to got %0b exp 100", c, {mem_req_o, d_done_o, timeout_o}); end
    end
    tick();
    n_cmp++; if ({mem_req_o, d_done_o, timeout_o} !== 3'b011) begin n_err++; $display("FAIL w_abort req/done/to got %0b exp 011", {mem_req_o, d_done_o, timeout_o}); end
    n_cmp++; if (d_rdata_o !== ERR) begin n_err++; $display("FAIL w_err_data got %0h exp %0h", d_rdata_o, ERR); end
    d_req_i = 1'b0;
    tick();
    resp_en = 1'b1; resp_delay = 0; resp_data = 32'hCAFE_0001;
    if_addr_i = 32'h20; if_req_i = 1'b1;
    tick(); tick();
    n_cmp++; if ({if_done_o, timeout_o} !== 2'b11) begin n_err++; $display("FAIL w_fetch done/to got %0b exp 11", {if_done_o, timeout_o}); end
    n_cmp++; if (if_rdata_o !== 32'hCAFE_0001) begin n_err++; $display("FAIL w_fetch_rdata got %0h exp cafe0001", if_rdata_o); end
    if_req_i = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_busy;
    resp_en = 1'b0;
    d_we_i = 1'b0; d_addr_i = 32'h180; d_req_i = 1'b1;
    tick(); tick();
    n_cmp++; if (mem_req_o !== 1'b1) begin n_err++; $display("FAIL r_busy_req got %0b exp 1", mem_req_o); end
    #1 rst_n_i = 1'b0;
    #1;
    n_cmp++; if ({mem_req_o, timeout_o, d_done_o, if_done_o} !== 4'b0000) begin n_err++; $display("FAIL r_async req/to/done got %0b exp 0000", {mem_req_o, timeout_o, d_done_o, if_done_o}); end
    n_cmp++; if ({mem_addr_o, if_rdata_o, d_rdata_o} !== 96'h0) begin n_err++; $display("FAIL r_async addr/rdata got %0h/%0h/%0h exp 0", mem_addr_o, if_rdata_o, d_rdata_o); end
    d_req_i = 1'b0;
    tick(); tick();
    rst_n_i = 1'b1;
    resp_data = 32'h9999_9999;
    force_ready = 1'b1;
    tick(); tick();
    force_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      n_cmp++; if ({mem_req_o, d_done_o, if_done_o} !== 3'b000) begin n_err++; $display("FAIL r_idle_ready_c%0d req/ddone/ifdone got %0b exp 000", c, {mem_req_o, d_done_o, if_done_o}); end
      tick();
    end
    n_cmp++; if (d_rdata_o !== 32'h0) begin n_err++; $display("FAIL r_idle_rdata got %0h exp 0", d_rdata_o); end
  endtask

  task automatic test_ready_at_timeout;
    resp_en = 1'b1; resp_delay = 7; resp_data = 32'h1234_5678;
    d_we_i = 1'b0; d_addr_i = 32'h1C0; d_req_i = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      n_cmp++; if ({mem_req_o, d_done_o} !== 2'b10) begin n_err++; $display("FAIL c_busy_c%0d req/done got %0b exp 10", c, {mem_req_o, d_done_o}); end
    end
    tick();
    n_cmp++; if ({d_done_o, timeout_o} !== 2'b10) begin n_err++; $display("FAIL c_done done/to got %0b exp 10", {d_done_o, timeout_o}); end
    n_cmp++; if (d_rdata_o !== 32'h1234_5678) begin n_err++; $display("FAIL c_rdata got %0h exp 12345678", d_rdata_o); end
    d_req_i = 1'b0;
    tick();
    n_cmp++; if (timeout_o !== 1'b0) begin n_err++; $display("FAIL c_timeout_after got %0b exp 0", timeout_o); end
  endtask

  initial begin
    rst_n_i = 1'b0;
    if_req_i = 1'b0; if_addr_i = '0;
    d_req_i = 1'b0; d_we_i = 1'b0; d_addr_i = '0; d_wdata_i = '0;
    resp_en = 1'b1; resp_delay = 0; resp_data = '0; force_ready = 1'b0;
    test_reset();
    test_single_fetch();
    test_data_priority();
    test_streak();
    test_watchdog();
    test_reset_mid_busy();
    test_ready_at_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequencer/arbiter sharing one unified single-port memory between the IF stage (instruction fetch, read-only) and the MEM stage (data load/store) of the pipelined CPU.
- Issues one transaction at a time to a variable-latency memory with a ready handshake and returns read data to the owning requester.
- Drives a pipeline-wide stall while any request is pending.
- Data has priority over fetch, with a bounded-starvation guarantee for fetch and a watchdog timeout.

Parameters:
AW, 32, address width
DW, 32, data width
MAX_D_STREAK, 4, max consecutive data grants while fetch is waiting; 0 = fetch may starve
TIMEOUT, 64, cycles a transaction may wait for mem_ready_i before abort; 0 = watchdog disabled
ERR_DATA, 32'h0000_0000, read data returned on an aborted transaction

Ports:
clk_i  in  1  clock, rising edge
rst_n_i  in  1  asynchronous active-low reset
if_req_i  in  1  fetch request; held with if_addr_i until if_done_o
if_addr_i  in  AW  fetch address
if_rdata_o  out  DW  fetched instruction; valid with if_done_o, held until next fetch completion
if_done_o  out  1  one-cycle fetch completion pulse
d_req_i  in  1  data request; held with d_we_i/d_addr_i/d_wdata_i until d_done_o
d_we_i  in  1  1 = store, 0 = load
d_addr_i  in  AW  data address
d_wdata_i  in  DW  store data
d_rdata_o  out  DW  load data; valid with d_done_o, held until next data completion
d_done_o  out  1  one-cycle data completion pulse
mem_req_o  out  1  memory request, registered
mem_we_o  out  1  memory write enable
mem_addr_o  out  AW  memory address
mem_wdata_o  out  DW  memory write data
mem_rdata_i  in  DW  memory read data; valid when mem_ready_i = 1
mem_ready_i  in  1  memory completion; sampled only while mem_req_o = 1
stall_o  out  1  pipeline stall
timeout_o  out  1  sticky watchdog error flag

Behaviour:
- Reset (asynchronous, any state, including mid-transaction):
  - state = IDLE.
  - All outputs 0: mem_req_o/we/addr/wdata, both done pulses, both rdata registers, timeout_o.
  - streak and watchdog counters = 0.
  - An in-flight memory transaction is abandoned. No done pulse follows reset.
- FSM states:
  - IDLE
  - BUSY_D (data transaction outstanding)
  - BUSY_IF (fetch transaction outstanding)
- Arbitration in IDLE:
  - A request is eligible if its req_i = 1 and its done_o is 0 in this cycle (a stale req in the cycle after done is ignored).
  - Data eligible and not (fetch eligible and streak = MAX_D_STREAK with MAX_D_STREAK != 0): grant data, go to BUSY_D.
  - Otherwise, if fetch is eligible: grant fetch, go to BUSY_IF.
  - Otherwise: stay in IDLE.
- On a grant:
  - mem_req_o = 1 in the next cycle; we/addr/wdata are captured from the granted port and held stable until completion.
  - mem_we_o = 0 for fetch.
- Streak counter:
  - Increments on a data grant while fetch is eligible.
  - Clears on a fetch grant, or on any data grant with fetch not eligible.
  - Saturates at MAX_D_STREAK.
- Completion:
  - In BUSY_x with mem_ready_i = 1, capture mem_rdata_i into the owner's rdata register (loads and fetches only; a store leaves d_rdata_o unchanged).
  - Pulse the owner's done_o in the next cycle, drop mem_req_o in that same cycle, and return to IDLE.
  - Minimum latency: req at cycle 0, mem_req_o at cycle 1, mem_ready_i at cycle 1, done/rdata at cycle 2.
  - Next grant is issued in the done cycle, so mem_req_o is high again at cycle 3 (one idle cycle between transactions).
- mem_ready_i while in IDLE, or while mem_req_o = 0, is ignored.
- Watchdog:
  - Counter clears on every grant and increments each BUSY cycle without mem_ready_i.
  - On reaching TIMEOUT (TIMEOUT != 0): abort the transaction, set timeout_o (cleared only by reset), pulse the owner's done_o, load its rdata with ERR_DATA, return to IDLE.
  - mem_ready_i in the same cycle as the count reaching TIMEOUT wins: normal completion, no error.
- stall_o is combinational:
  - stall_o = (if_req_i & ~if_done_o) | (d_req_i & ~d_done_o).
  - It drops in the cycle its done pulse is asserted.
- A requester deasserting req before its done is a protocol violation. The transaction still completes and the done pulse is still emitted.

Test Plan:
- Single fetch, if_addr_i = 0x40, mem_ready_i one cycle after mem_req_o with rdata 0x8C010004 -> mem_req_o high cycles 1-2, if_done_o at cycle 3, if_rdata_o = 0x8C010004, stall_o high cycles 0-2.
- if_req_i and d_req_i (store, addr 0x100, data 0xDEADBEEF) rise together, mem ready after 1 cycle -> data granted first with mem_we_o = 1; fetch granted in the d_done_o cycle; d_rdata_o unchanged.
- MAX_D_STREAK = 4, d_req_i reasserted continuously with fetch pending -> grants D,D,D,D,IF,D...; streak clears after the fetch grant.
- TIMEOUT = 8, mem_ready_i held 0 on a load -> abort after 8 busy cycles, d_done_o pulses, d_rdata_o = ERR_DATA, timeout_o = 1 and stays 1; a subsequent fetch with ready completes normally.
- rst_n_i low mid BUSY_D, then mem_ready_i pulses after reset release -> all outputs 0, no done pulse, mem_ready_i ignored in IDLE.
- mem_ready_i coincident with the watchdog count reaching TIMEOUT -> normal completion with mem_rdata_i, timeout_o stays 0.
